// File: rtl/rtc_pkg.sv
// rtc_pkg: shared field indices, BCD limits and ASCII codes for the RTC display path
package rtc_pkg;
  localparam logic [2:0] FLD_SEC   = 3'd0;
  localparam logic [2:0] FLD_MIN   = 3'd1;
  localparam logic [2:0] FLD_HOUR  = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_MONTH = 3'd4;
  localparam logic [2:0] FLD_YEAR  = 3'd5;
  localparam logic [2:0] FLD_NONE  = 3'd7;
  localparam logic [7:0] SEC_MIN    = 8'h00;
  localparam logic [7:0] SEC_MAX    = 8'h59;
  localparam logic [7:0] MINUTE_MIN = 8'h00;
  localparam logic [7:0] MINUTE_MAX = 8'h59;
  localparam logic [7:0] HOUR12_MIN = 8'h01;
  localparam logic [7:0] HOUR12_MAX = 8'h12;
  localparam logic [7:0] HOUR24_MIN = 8'h00;
  localparam logic [7:0] HOUR24_MAX = 8'h23;
  localparam logic [7:0] DAY_MIN    = 8'h01;
  localparam logic [7:0] DAY_MAX    = 8'h31;
  localparam logic [7:0] MONTH_MIN  = 8'h01;
  localparam logic [7:0] MONTH_MAX  = 8'h12;
  localparam logic [7:0] YEAR_MIN   = 8'h00;
  localparam logic [7:0] YEAR_MAX   = 8'h99;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_COLON = 7'h3A;
  localparam logic [6:0] CH_SLASH = 7'h2F;
  localparam logic [6:0] CH_ZERO  = 7'h30;
  localparam logic [6:0] CH_A     = 7'h41;
  localparam logic [6:0] CH_P     = 7'h50;
  localparam logic [6:0] CH_M     = 7'h4D;
endpackage

// File: rtl/rtc_bcd_check.sv
// rtc_bcd_check: a byte is accepted when both nibbles are decimal digits and it lies in [lo, hi]
module rtc_bcd_check (
  input  logic [7:0] value,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic       ok
);
  assign ok = value[7:4] <= 4'd9 && value[3:0] <= 4'd9 && value >= lo && value <= hi;
endmodule

// File: rtl/rtc_display_buffer.sv
// rtc_display_buffer: BCD shadow/display time registers with frame-aligned commit and blinking ASCII readout; RTC_DISPLAY_AMPM_EN adds an AM/PM suffix
module rtc_display_buffer
  import rtc_pkg::*;
#(
  parameter int BLINK_FRAMES = 30,
  parameter int CHAR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  input  logic              ensec,
  input  logic              enmin,
  input  logic              enhour,
  input  logic              enday,
  input  logic              enmonth,
  input  logic              enyear,
  input  logic              mode12,
  input  logic              frame_sync,
  input  logic              edit_mode,
  input  logic [2:0]        edit_field,
  input  logic [4:0]        char_idx,
  output logic [CHAR_W-1:0] char_code,
  output logic              pm,
  output logic              bcd_err,
  output logic              sel_err,
  output logic              dirty
);
  localparam logic [7:0] RST_F [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
  logic [5:0] en;
  logic       onehot, ok, is_hour, sh_pm, hidden, blank;
  logic [2:0] fld, fi;
  logic [7:0] val, lo, hi;
  logic [7:0] sh [6];
  logic [7:0] disp [6];
  logic [5:0] cnt;
  logic [4:0] grp, pos;
  logic [6:0] ch;
`ifdef RTC_DISPLAY_AMPM_EN
  logic       disp_m12;
`endif
  assign en      = {enyear, enmonth, enday, enhour, enmin, ensec};
  assign onehot  = en != 6'd0 && (en & (en - 6'd1)) == 6'd0;
  assign fld     = en[0] ? FLD_SEC : en[1] ? FLD_MIN : en[2] ? FLD_HOUR :
                   en[3] ? FLD_DAY : en[4] ? FLD_MONTH : FLD_YEAR;
  assign is_hour = fld == FLD_HOUR;
  assign val = is_hour ? (mode12 ? {3'b000, rd_data[4:0]} : {2'b00, rd_data[5:0]}) :
               (fld == FLD_SEC || fld == FLD_MIN) ? {1'b0, rd_data[6:0]} :
               fld == FLD_DAY ? {2'b00, rd_data[5:0]} :
               fld == FLD_MONTH ? {3'b000, rd_data[4:0]} : rd_data;
  assign lo  = fld == FLD_SEC ? SEC_MIN : fld == FLD_MIN ? MINUTE_MIN :
               is_hour ? (mode12 ? HOUR12_MIN : HOUR24_MIN) :
               fld == FLD_DAY ? DAY_MIN : fld == FLD_MONTH ? MONTH_MIN : YEAR_MIN;
  assign hi  = fld == FLD_SEC ? SEC_MAX : fld == FLD_MIN ? MINUTE_MAX :
               is_hour ? (mode12 ? HOUR12_MAX : HOUR24_MAX) :
               fld == FLD_DAY ? DAY_MAX : fld == FLD_MONTH ? MONTH_MAX : YEAR_MAX;
  rtc_bcd_check u_chk (.value(val), .lo(lo), .hi(hi), .ok(ok));
  // Shadow capture and frame-aligned commit; a capture in the commit cycle re-arms dirty
  always_ff @(posedge clk) begin
    if (reset) begin
      sh      <= RST_F;
      disp    <= RST_F;
      sh_pm   <= 1'b0;
      pm      <= 1'b0;
      dirty   <= 1'b0;
      bcd_err <= 1'b0;
      sel_err <= 1'b0;
`ifdef RTC_DISPLAY_AMPM_EN
      disp_m12 <= 1'b0;
`endif
    end else begin
      if (frame_sync && dirty) begin
        disp  <= sh;
        pm    <= sh_pm;
        dirty <= 1'b0;
`ifdef RTC_DISPLAY_AMPM_EN
        disp_m12 <= mode12;
`endif
      end
      if (rd_valid && !onehot) sel_err <= 1'b1;
      else if (rd_valid && !ok) bcd_err <= 1'b1;
      else if (rd_valid) begin
        sh[fld] <= val;
        dirty   <= 1'b1;
        if (is_hour) sh_pm <= mode12 & rd_data[5];
      end
    end
  end
  // Blink timer runs on frame pulses only while editing, otherwise parked visible
  always_ff @(posedge clk) begin
    if (reset || !edit_mode) begin
      cnt    <= 6'd0;
      hidden <= 1'b0;
    end else if (frame_sync) begin
      cnt    <= cnt == 6'(BLINK_FRAMES - 1) ? 6'd0 : cnt + 6'd1;
      hidden <= cnt == 6'(BLINK_FRAMES - 1) ? ~hidden : hidden;
    end
  end
  // Character map: positions come in groups of three (tens, units, separator)
  always_comb begin
    grp = char_idx / 5'd3;
    pos = char_idx % 5'd3;
    fi  = FLD_NONE;
    ch  = CH_SPACE;
    if (char_idx <= 5'd16) begin
      if (pos == 5'd2) ch = grp < 5'd2 ? CH_COLON : grp == 5'd2 ? CH_SPACE : CH_SLASH;
      else begin
        fi = grp == 5'd0 ? FLD_HOUR : grp == 5'd1 ? FLD_MIN : grp == 5'd2 ? FLD_SEC : grp[2:0];
        ch = CH_ZERO + {3'b000, pos == 5'd0 ? disp[fi][7:4] : disp[fi][3:0]};
      end
    end
`ifdef RTC_DISPLAY_AMPM_EN
    else if (disp_m12 && (char_idx == 5'd18 || char_idx == 5'd19)) begin
      fi = FLD_HOUR;
      ch = char_idx == 5'd19 ? CH_M : pm ? CH_P : CH_A;
    end
`endif
  end
  assign blank = edit_mode && hidden && fi != FLD_NONE && fi == edit_field;
  // Registered character port, one cycle behind char_idx
  always_ff @(posedge clk) begin
    if (reset) char_code <= CHAR_W'(CH_SPACE);
    else char_code <= CHAR_W'(blank ? CH_SPACE : ch);
  end
endmodule
